// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types, LFSR taps and colour decode for the Simon round sequencer
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    RESTART,
    WIN,
    LOSE
  } state_t;

  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [3:0] colour_onehot(input logic [1:0] colour);
    logic [3:0] onehot;
    onehot = 4'b0001 << colour;
    return onehot;
  endfunction

endpackage

// File: rtl/simon_round_ctrl_if.sv
// rtl/simon_round_ctrl_if.sv - buttons, timer and LED/status signals around the round sequencer
interface simon_round_ctrl_if;

  logic       start_game;
  logic [3:0] btn;
  logic       times_up;
  logic       timer_start;
  logic [3:0] led;
  logic [4:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  // Sequencer side
  modport master (
    input  start_game, btn, times_up,
    output timer_start, led, level, busy, win, lose
  );

  // Button block, timer and LED driver side
  modport slave (
    output start_game, btn, times_up,
    input  timer_start, led, level, busy, win, lose
  );

endinterface

// File: rtl/simon_lfsr8.sv
// rtl/simon_lfsr8.sv - free-running 8-bit Fibonacci LFSR supplying random colours
module simon_lfsr8
  import simon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  output logic [1:0] colour
);

  logic [7:0] state_q;

  // Shift every cycle regardless of game state so colour timing depends on the player
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= {state_q[6:0], ^(state_q & LFSR_TAPS)};
    end
  end

  assign colour = state_q[1:0];

endmodule

// File: rtl/simon_round_ctrl.sv
// rtl/simon_round_ctrl.sv - Simon round sequencer: grow pattern, play it back, check presses
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         SHOW_CYCLES = 50_000_000,
  parameter int         GAP_CYCLES  = 25_000_000,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  simon_round_ctrl_if.master bus
);

  localparam int CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] idx;
  logic [LW-1:0] len;
  logic          wait_first;
  logic [3:0]    led_q;
  logic          timer_q;
  logic          busy_q;
  logic          win_q;
  logic          lose_q;

  logic [1:0]    seq [MAX_LEN];
  logic [1:0]    lfsr_colour;
  logic [LW-1:0] idx_next;
  logic [1:0]    head_colour;
  logic [1:0]    next_colour;
  logic [3:0]    want;
  logic          at_last;
  logic          bad_btn;

  simon_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .colour (lfsr_colour)
  );

  assign idx_next = idx + LW'(1);
  assign at_last  = (idx == len - LW'(1));
  // Step 0 of playback: on the very first round seq[0] is still being written this cycle
  assign head_colour = (len == '0) ? lfsr_colour : seq[0];
  assign next_colour = seq[idx_next[AW-1:0]];
  assign want        = colour_onehot(seq[idx[AW-1:0]]);
  assign bad_btn     = (bus.btn != 4'b0000) && !$onehot(bus.btn);

  // Pattern storage; deliberately not reset so the player cannot observe stale entries anyway
  always_ff @(posedge clock) begin
    if (state == ADD) begin
      seq[len[AW-1:0]] <= lfsr_colour;
    end
  end

  // Round sequencer with outputs registered alongside the state they belong to
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      len        <= '0;
      wait_first <= 1'b0;
      led_q      <= 4'b0000;
      timer_q    <= 1'b0;
      busy_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, WIN, LOSE: begin
          if (bus.start_game) begin
            state  <= ADD;
            len    <= '0;
            win_q  <= 1'b0;
            lose_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end

        ADD: begin
          len   <= len + LW'(1);
          idx   <= '0;
          cnt   <= '0;
          state <= SHOW_ON;
          led_q <= colour_onehot(head_colour);
        end

        SHOW_ON: begin
          if (cnt == SHOW_LAST) begin
            cnt   <= '0;
            state <= SHOW_OFF;
            led_q <= 4'b0000;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        SHOW_OFF: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (at_last) begin
              idx        <= '0;
              state      <= WAIT_IN;
              timer_q    <= 1'b1;
              wait_first <= 1'b1;
            end else begin
              idx   <= idx_next;
              state <= SHOW_ON;
              led_q <= colour_onehot(next_colour);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_IN: begin
          wait_first <= 1'b0;
          // The timer flag is one cycle stale on entry, so it only counts from the second cycle
          if ((!wait_first && !bus.times_up) || bad_btn) begin
            state   <= LOSE;
            lose_q  <= 1'b1;
            busy_q  <= 1'b0;
            timer_q <= 1'b0;
          end else if (bus.btn == want) begin
            timer_q <= 1'b0;
            if (at_last && (len == LEN_MAX)) begin
              state  <= WIN;
              win_q  <= 1'b1;
              busy_q <= 1'b0;
            end else if (at_last) begin
              state <= ADD;
            end else begin
              idx   <= idx_next;
              state <= RESTART;
            end
          end else if (bus.btn != 4'b0000) begin
            state   <= LOSE;
            lose_q  <= 1'b1;
            busy_q  <= 1'b0;
            timer_q <= 1'b0;
          end
        end

        RESTART: begin
          state      <= WAIT_IN;
          timer_q    <= 1'b1;
          wait_first <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          led_q   <= 4'b0000;
          timer_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.timer_start = timer_q;
  assign bus.led         = led_q;
  assign bus.level       = 5'(len);
  assign bus.busy        = busy_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// tb/tb_simon_round_ctrl.sv - table-driven bench for the Simon round sequencer
module tb_simon_round_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  simon_round_ctrl_if bus ();

  simon_round_ctrl #(
    .MAX_LEN     (2),
    .SHOW_CYCLES (4),
    .GAP_CYCLES  (2),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference colour source: x^8+x^6+x^5+x^4+1, seeded like the design
  logic [7:0] m_lfsr;
  always @(posedge clock or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  logic [1:0] seq_m [4];
  int errors = 0;
  int checks = 0;
  int row_no = 0;

  // bk: 0 no press, 1 correct press of seq_m[bi], 2 wrong single press, 3 raw braw
  typedef struct {
    int         rep;
    bit         start;
    int         bk;
    int         bi;
    logic [3:0] braw;
    bit         tup;
    bit         cap;
    int         lk;
    int         li;
    bit         ts;
    int         lvl;
    bit         busy;
    bit         win;
    bit         lose;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] r;
    r = 4'b0001 << c;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic row(input int rep, input bit start, input int bk, input int bi,
                     input logic [3:0] braw, input bit tup, input bit cap,
                     input int lk, input int li, input bit ts, input int lvl,
                     input bit busy, input bit win, input bit lose);
    vec_t v;
    v.rep = rep; v.start = start; v.bk = bk; v.bi = bi; v.braw = braw;
    v.tup = tup; v.cap = cap; v.lk = lk; v.li = li; v.ts = ts; v.lvl = lvl;
    v.busy = busy; v.win = win; v.lose = lose;
    tbl.push_back(v);
  endtask

  task automatic start_row();
    row(1, 1, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  // ADD cycle, then lvl steps of 4 lit + 2 dark cycles, ending on WAIT_IN entry
  task automatic playback(input int lvl);
    for (int k = 0; k < lvl; k++) begin
      row(1, 0, 0, 0, 4'h0, 1, (k == 0), 1, k, 0, lvl, 1, 0, 0);
      row(3, 1, 0, 0, 4'h0, 1, 0, 1, k, 0, lvl, 1, 0, 0);
      row(1, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, lvl, 1, 0, 0);
      row(1, 0, 3, 0, 4'b0001, 1, 0, 0, 0, 0, lvl, 1, 0, 0);
    end
    row(1, 0, 0, 0, 4'h0, 1, 0, 0, 0, 1, lvl, 1, 0, 0);
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] led, input bit ts,
                               input int lvl, input bit busy, input bit win, input bit lose);
    chk({tag, ".led"}, bus.led, led);
    chk({tag, ".timer_start"}, bus.timer_start, ts);
    chk({tag, ".level"}, bus.level, lvl);
    chk({tag, ".busy"}, bus.busy, busy);
    chk({tag, ".win"}, bus.win, win);
    chk({tag, ".lose"}, bus.lose, lose);
  endtask

  task automatic run_table();
    logic [1:0] wrong;
    logic [3:0] exp_led;
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        @(negedge clock);
        bus.start_game = tbl[i].start;
        bus.times_up   = tbl[i].tup;
        wrong          = seq_m[tbl[i].bi] + 2'd1;
        case (tbl[i].bk)
          0:       bus.btn = 4'b0000;
          1:       bus.btn = oh(seq_m[tbl[i].bi]);
          2:       bus.btn = oh(wrong);
          default: bus.btn = tbl[i].braw;
        endcase
        if (tbl[i].cap) seq_m[tbl[i].lvl - 1] = m_lfsr[1:0];
        @(posedge clock);
        #1;
        exp_led = (tbl[i].lk != 0) ? oh(seq_m[tbl[i].li]) : 4'b0000;
        check_outputs($sformatf("row%0d", row_no), exp_led, tbl[i].ts, tbl[i].lvl,
                      tbl[i].busy, tbl[i].win, tbl[i].lose);
      end
      row_no++;
    end
    tbl.delete();
    bus.start_game = 1'b0;
    bus.btn        = 4'b0000;
    bus.times_up   = 1'b1;
  endtask

  initial begin
    bus.start_game = 1'b0;
    bus.btn        = 4'b0000;
    bus.times_up   = 1'b1;
    repeat (3) @(negedge clock);
    check_outputs("reset", 4'b0000, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Round 1, stale timer flag ignored on first WAIT_IN cycle, then correct press
    start_row();
    playback(1);
    row(1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    row(1, 0, 1, 0, 4'h0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Round 2: correct first press -> RESTART, then wrong second press -> LOSE
    playback(2);
    row(1, 0, 1, 0, 4'h0, 1, 0, 0, 0, 0, 2, 1, 0, 0);
    row(1, 0, 0, 0, 4'h0, 1, 0, 0, 0, 1, 2, 1, 0, 0);
    row(1, 0, 2, 1, 4'h0, 1, 0, 0, 0, 0, 2, 0, 0, 1);
    row(2, 0, 3, 0, 4'b0001, 1, 0, 0, 0, 0, 2, 0, 0, 1);
    // New game from LOSE; timeout on second cycle beats a correct press
    start_row();
    playback(1);
    row(1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    row(1, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    // Two bits pressed together -> LOSE
    start_row();
    playback(1);
    row(1, 0, 3, 0, 4'b0011, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    // Full game to MAX_LEN=2 -> WIN
    start_row();
    playback(1);
    row(1, 0, 1, 0, 4'h0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    playback(2);
    row(1, 0, 1, 0, 4'h0, 1, 0, 0, 0, 0, 2, 1, 0, 0);
    row(1, 0, 0, 0, 4'h0, 1, 0, 0, 0, 1, 2, 1, 0, 0);
    row(1, 0, 1, 1, 4'h0, 1, 0, 0, 0, 0, 2, 0, 1, 0);
    row(2, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 2, 0, 1, 0);
    // New game from WIN, stop inside SHOW_ON
    start_row();
    row(1, 0, 0, 0, 4'h0, 1, 1, 1, 0, 0, 1, 1, 0, 0);
    row(1, 0, 0, 0, 4'h0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    run_table();

    // Reset mid-cycle during SHOW_ON takes effect without waiting for a clock edge
    #2;
    reset = 1'b1;
    #1;
    check_outputs("rst_show", 4'b0000, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    // Reset mid-cycle in WAIT_IN drops timer_start immediately
    start_row();
    playback(1);
    run_table();
    #2;
    reset = 1'b1;
    #1;
    check_outputs("rst_wait", 4'b0000, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    row(2, 0, 3, 0, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
- Round sequencer for the Simon game. Each round appends one random colour, plays the pattern on the LEDs, then checks the player's button presses.
- Drives the external 5-second timeout timer: start/hold through timer_start, and reads its active-low expiry flag times_up.
- Sits between the debounced button block, the LED drivers and the timer instance.

Parameters:
- MAX_LEN, 16, rounds needed to win; sequence storage depth (2 bits per entry).
- SHOW_CYCLES, 50_000_000, clock cycles an LED stays lit during playback.
- GAP_CYCLES, 25_000_000, dark cycles after each playback step.
- LFSR_SEED, 8'hA5, non-zero reset value of the colour LFSR.

Ports:
- clock, input, 1, system clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-high reset.
- start_game, input, 1, single-cycle pulse; starts a new game from IDLE, WIN or LOSE.
- btn, input, 4, debounced single-cycle press pulses, one bit per colour (bit0..bit3).
- times_up, input, 1, from the timer; 1 = running or idle, 0 = expired.
- timer_start, output, 1, held 1 while the timer must run; 0 clears it.
- led, output, 4, one-hot colour during playback, else 0.
- level, output, 5, current sequence length (0..MAX_LEN).
- busy, output, 1, high in ADD, SHOW_ON, SHOW_OFF, WAIT_IN and RESTART.
- win, output, 1, sticky high in WIN.
- lose, output, 1, sticky high in LOSE.

Behaviour:
- Reset: state=IDLE, led=0, timer_start=0, level=0, busy=0, win=0, lose=0, idx=0, cnt=0, lfsr=LFSR_SEED. Sequence storage is not cleared.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Shifts every cycle in every state. New colour = lfsr[1:0].
- IDLE, WIN, LOSE: start_game -> ADD and len<=0. On leaving WIN or LOSE, win and lose clear. start_game is ignored in all other states.
- ADD (1 cycle): seq[len]<=lfsr[1:0]; len<=len+1; idx<=0; cnt<=0 -> SHOW_ON.
- SHOW_ON: led=onehot(seq[idx]). After SHOW_CYCLES cycles -> SHOW_OFF with cnt<=0.
- SHOW_OFF: led=0. After GAP_CYCLES cycles:
  - if idx==len-1: idx<=0 -> WAIT_IN;
  - else idx<=idx+1 -> SHOW_ON.
- Timer control: timer_start=1 only in WAIT_IN, 0 in every other state. Every entry to WAIT_IN is therefore preceded by at least one cycle with timer_start=0, which clears the timer.
- WAIT_IN:
  - First cycle after entry: times_up is ignored, because the timer's flag is registered and may be stale.
  - Priority each cycle:
    1. times_up==0 (not the first cycle) -> LOSE.
    2. btn!=0 and not exactly one bit set -> LOSE.
    3. btn==onehot(seq[idx]):
       - idx==len-1 and len==MAX_LEN -> WIN;
       - idx==len-1 and len<MAX_LEN -> ADD;
       - otherwise idx<=idx+1 -> RESTART.
    4. Single wrong bit -> LOSE.
  - Timeout beats a same-cycle button press.
- RESTART (1 cycle): timer_start=0 -> WAIT_IN. This gives a fresh 5 s timeout per press.
- Buttons outside WAIT_IN are ignored.
- level equals len at all times and holds its value in WIN and LOSE.
- Counter widths: cnt is $clog2(max(SHOW_CYCLES,GAP_CYCLES)+1) bits; idx and len are $clog2(MAX_LEN+1) bits. No wrap occurs, because len never exceeds MAX_LEN.
- Reset asserted mid-round: immediate return to the reset values above; timer_start drops asynchronously.

Decomposition:
- Package simon_pkg:
  - state encoding enum (IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, RESTART, WIN, LOSE);
  - colour-to-one-hot function;
  - LFSR tap constant.
- One natural sub-module: simon_lfsr8 (free-running 8-bit LFSR with seed parameter and async reset).

Test Plan:
- Reset, then start_game with SHOW_CYCLES=4 and GAP_CYCLES=2 -> level=1; led one-hot of lfsr[1:0] for 4 cycles, then 0 for 2 cycles; timer_start rises on the WAIT_IN entry cycle.
- In WAIT_IN, press the correct button -> ADD, level=2; playback shows 2 steps with seq[0] unchanged.
- Round 2: correct first press -> RESTART, timer_start=0 for exactly 1 cycle, then 1; wrong second press -> lose=1, timer_start=0, level holds 2.
- Hold times_up=0 during the WAIT_IN first cycle -> no effect. Times_up=0 on the second cycle with a simultaneous correct btn -> LOSE.
- btn=4'b0011 in WAIT_IN -> LOSE. start_game from LOSE -> lose=0, level=1.
- MAX_LEN=2: two correct rounds -> win=1, busy=0. Assert reset during SHOW_ON -> led=0, level=0 and state IDLE in the same cycle.
